// File: rtl/cpu_types_pkg.sv
// Shared CPU types: ALU opcode/word types, ALU op codes, flag bit positions
// and the ALU-sharing arbiter state encoding.
package cpu_types_pkg;

    typedef logic [3:0]  aluop_t;
    typedef logic [31:0] word_t;

    localparam aluop_t ALU_ADD  = 4'd0;
    localparam aluop_t ALU_SUB  = 4'd1;
    localparam aluop_t ALU_AND  = 4'd2;
    localparam aluop_t ALU_OR   = 4'd3;
    localparam aluop_t ALU_XOR  = 4'd4;
    localparam aluop_t ALU_SLT  = 4'd5;
    localparam aluop_t ALU_SLTU = 4'd6;
    localparam aluop_t ALU_SLL  = 4'd7;
    localparam aluop_t ALU_SRL  = 4'd8;
    localparam aluop_t ALU_SRA  = 4'd9;

    localparam int ALU_FLAG_Z = 0;
    localparam int ALU_FLAG_N = 1;
    localparam int ALU_FLAG_V = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_t;

endpackage

// File: rtl/alu_share_arb_if.sv
// Requester-side bundle of the shared-ALU arbiter: op request channel and
// result response channel, one lane per requester.
interface alu_share_arb_if #(
    parameter int NREQ = 2,
    parameter int IDW  = 1
);
    import cpu_types_pkg::*;

    logic   [NREQ-1:0] req_valid;
    logic   [NREQ-1:0] req_ready;
    aluop_t [NREQ-1:0] req_aluop;
    word_t  [NREQ-1:0] req_porta;
    word_t  [NREQ-1:0] req_portb;
    logic   [NREQ-1:0] rsp_valid;
    logic   [NREQ-1:0] rsp_ready;
    word_t             rsp_portout;
    logic   [2:0]      rsp_flags;
    logic   [IDW-1:0]  rsp_id;

    modport master (
        output req_valid, req_aluop, req_porta, req_portb, rsp_ready,
        input  req_ready, rsp_valid, rsp_portout, rsp_flags, rsp_id
    );

    modport slave (
        input  req_valid, req_aluop, req_porta, req_portb, rsp_ready,
        output req_ready, rsp_valid, rsp_portout, rsp_flags, rsp_id
    );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request scanning upward from
// the slot after the previous grant, wrapping modulo NREQ.
module rr_pick #(
    parameter int NREQ = 2,
    parameter int IDW  = 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  last,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_id,
    output logic            found
);

    // Circular scan; the first hit wins and masks all later candidates
    always_comb begin : scan
        logic [IDW-1:0] idx_s;
        logic           hit_s;
        gnt    = '0;
        gnt_id = '0;
        found  = 1'b0;
        idx_s  = '0;
        hit_s  = 1'b0;
        for (int i = 1; i <= NREQ; i++) begin
            idx_s      = IDW'((int'(last) + i) % NREQ);
            hit_s      = req[idx_s] & ~found;
            gnt[idx_s] = gnt[idx_s] | hit_s;
            gnt_id     = hit_s ? idx_s : gnt_id;
            found      = found | hit_s;
        end
    end

endmodule

// File: rtl/alu_share_arb.sv
// Round-robin sequencer sharing one external combinational ALU between NREQ
// requesters; one op in flight, result returned over a valid/ready channel.
module alu_share_arb
    import cpu_types_pkg::*;
#(
    parameter int NREQ = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    alu_share_arb_if.slave       bus,
    output aluop_t               alu_aluop,
    output word_t                alu_porta,
    output word_t                alu_portb,
    input  word_t                alu_portout,
    input  logic                 alu_zero,
    input  logic                 alu_negative,
    input  logic                 alu_overflow,
    output logic                 busy
);

    localparam int IDW = (NREQ > 2) ? $clog2(NREQ) : 1;

    localparam logic [1:0] S_IDLE = IDLE;
    localparam logic [1:0] S_EXEC = EXEC;
    localparam logic [1:0] S_RESP = RESP;

    logic [1:0]      state_r;
    logic [IDW-1:0]  last_gnt_r;
    logic [IDW-1:0]  gid_r;
    aluop_t          aluop_r;
    word_t           porta_r;
    word_t           portb_r;
    word_t           res_r;
    logic [2:0]      flags_r;

    logic [NREQ-1:0] gnt_s;
    logic [IDW-1:0]  gnt_id_s;
    logic            found_s;

    rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
        .req    (bus.req_valid),
        .last   (last_gnt_r),
        .gnt    (gnt_s),
        .gnt_id (gnt_id_s),
        .found  (found_s)
    );

    // Sequencer: accept in IDLE, capture ALU result in EXEC, hand back in RESP
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= S_IDLE;
            last_gnt_r <= IDW'(NREQ - 1);
            gid_r      <= '0;
            aluop_r    <= 4'd0;
            porta_r    <= 32'd0;
            portb_r    <= 32'd0;
            res_r      <= 32'd0;
            flags_r    <= 3'd0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (found_s) begin
                        aluop_r <= bus.req_aluop[gnt_id_s];
                        porta_r <= bus.req_porta[gnt_id_s];
                        portb_r <= bus.req_portb[gnt_id_s];
                        gid_r   <= gnt_id_s;
                        state_r <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    res_r               <= alu_portout;
                    flags_r[ALU_FLAG_Z] <= alu_zero;
                    flags_r[ALU_FLAG_N] <= alu_negative;
                    flags_r[ALU_FLAG_V] <= alu_overflow;
                    state_r             <= S_RESP;
                end
                S_RESP: begin
                    // Only the owner's ready retires the response
                    if (bus.rsp_ready[gid_r]) begin
                        last_gnt_r <= gid_r;
                        state_r    <= S_IDLE;
                    end
                end
                default: state_r <= S_IDLE;
            endcase
        end
    end

    // Grant strobe and response-owner decode from the state registers
    always_comb begin
        if ((state_r == S_IDLE) && !rst) begin
            bus.req_ready = gnt_s;
        end else begin
            bus.req_ready = '0;
        end
        if (state_r == S_RESP) begin
            bus.rsp_valid = NREQ'(1'b1) << gid_r;
        end else begin
            bus.rsp_valid = '0;
        end
    end

    assign alu_aluop       = aluop_r;
    assign alu_porta       = porta_r;
    assign alu_portb       = portb_r;
    assign bus.rsp_portout = res_r;
    assign bus.rsp_flags   = flags_r;
    assign bus.rsp_id      = gid_r;
    assign busy            = (state_r != S_IDLE);

endmodule

// File: tb/tb_alu_share_arb.sv
// Self-checking bench for alu_share_arb: directed vector table, multi-cycle
// corner sequences and a randomized run against a transaction-level model.
module tb_alu_share_arb;
    import cpu_types_pkg::*;

    localparam int NREQ = 2;

    logic   clk = 1'b0;
    logic   rst;
    aluop_t alu_aluop;
    word_t  alu_porta, alu_portb, alu_portout;
    logic   alu_zero, alu_negative, alu_overflow;
    logic   busy;

    int n_pass = 0;
    int n_chk  = 0;

    alu_share_arb_if #(.NREQ(NREQ), .IDW(1)) bus ();

    alu_share_arb #(.NREQ(NREQ)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .alu_aluop    (alu_aluop),
        .alu_porta    (alu_porta),
        .alu_portb    (alu_portb),
        .alu_portout  (alu_portout),
        .alu_zero     (alu_zero),
        .alu_negative (alu_negative),
        .alu_overflow (alu_overflow),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // Behavioural ALU: returns {overflow, negative, zero, result}
    function automatic logic [34:0] alu_calc(aluop_t op, word_t a, word_t b);
        word_t r;
        logic  v;
        r = 32'd0;
        v = 1'b0;
        case (op)
            ALU_ADD:  begin r = a + b; v = (a[31] == b[31]) && (r[31] != a[31]); end
            ALU_SUB:  begin r = a - b; v = (a[31] != b[31]) && (r[31] != a[31]); end
            ALU_AND:  r = a & b;
            ALU_OR:   r = a | b;
            ALU_XOR:  r = a ^ b;
            ALU_SLT:  r = {31'd0, $signed(a) < $signed(b)};
            ALU_SLTU: r = {31'd0, a < b};
            ALU_SLL:  r = a << b[4:0];
            ALU_SRL:  r = a >> b[4:0];
            ALU_SRA:  r = word_t'($signed(a) >>> b[4:0]);
            default:  r = 32'd0;
        endcase
        return {v, r[31], (r == 32'd0), r};
    endfunction

    always_comb begin
        {alu_overflow, alu_negative, alu_zero, alu_portout} = alu_calc(alu_aluop, alu_porta, alu_portb);
    end

    // Fair-share rule: winner is the pending requester nearest after the last served one
    function automatic int rr_winner(logic [NREQ-1:0] pend, int last);
        int best, best_d, d;
        best   = 0;
        best_d = NREQ + 1;
        for (int j = 0; j < NREQ; j++) begin
            d = (j - last - 1 + 2 * NREQ) % NREQ;
            if (pend[j] && d < best_d) begin
                best   = j;
                best_d = d;
            end
        end
        return best;
    endfunction

    function automatic logic [NREQ-1:0] onehot(int i);
        logic [NREQ-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic nxt();
        @(negedge clk);
    endtask

    typedef struct {
        int     who;
        aluop_t op;
        word_t  a;
        word_t  b;
        word_t  exp_out;
        logic [2:0] exp_flags;
    } vec_t;

    vec_t vecs[12];

    task automatic run_single(input vec_t v);
        logic [NREQ-1:0] oh;
        oh = onehot(v.who);
        bus.req_aluop[v.who] = v.op;
        bus.req_porta[v.who] = v.a;
        bus.req_portb[v.who] = v.b;
        bus.req_valid        = oh;
        #1;
        chk("vec_grant", bus.req_ready, oh);
        nxt();
        bus.req_valid = '0;
        chk("vec_exec", {busy, bus.rsp_valid, bus.req_ready}, {1'b1, 2'b00, 2'b00});
        chk("vec_alu_in", {alu_aluop, alu_porta, alu_portb}, {v.op, v.a, v.b});
        nxt();
        chk("vec_rsp_valid", bus.rsp_valid, oh);
        chk("vec_rsp_data", {bus.rsp_flags, bus.rsp_portout}, {v.exp_flags, v.exp_out});
        chk("vec_rsp_id", bus.rsp_id, v.who);
        bus.rsp_ready = oh;
        nxt();
        bus.rsp_ready = '0;
        chk("vec_idle", {busy, bus.rsp_valid}, 3'b000);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [NREQ-1:0] gseq[4];
        logic [NREQ-1:0] pend;
        aluop_t          pop[NREQ];
        word_t           pa[NREQ], pb[NREQ];
        logic [34:0]     exp;
        int ng, nr, bad, w, last;

        vecs[0]  = '{0, ALU_ADD,  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 3'b110};
        vecs[1]  = '{1, ALU_SUB,  32'd5,         32'd5,         32'h0000_0000, 3'b001};
        vecs[2]  = '{0, ALU_AND,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 3'b010};
        vecs[3]  = '{1, ALU_OR,   32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 3'b001};
        vecs[4]  = '{0, ALU_XOR,  32'hFFFF_FFFF, 32'h0000_FFFF, 32'hFFFF_0000, 3'b010};
        vecs[5]  = '{1, ALU_SLT,  32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 3'b000};
        vecs[6]  = '{0, ALU_SLTU, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 3'b001};
        vecs[7]  = '{1, ALU_SLL,  32'h0000_0001, 32'd31,        32'h8000_0000, 3'b010};
        vecs[8]  = '{0, ALU_SRA,  32'h8000_0000, 32'd4,         32'hF800_0000, 3'b010};
        vecs[9]  = '{1, ALU_SRL,  32'h8000_0000, 32'd4,         32'h0800_0000, 3'b000};
        vecs[10] = '{0, ALU_SUB,  32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 3'b100};
        vecs[11] = '{1, 4'hF,     32'h0000_0001, 32'h0000_0002, 32'h0000_0000, 3'b001};

        rst           = 1'b1;
        bus.req_valid = '0;
        bus.req_aluop = '0;
        bus.req_porta = '0;
        bus.req_portb = '0;
        bus.rsp_ready = '0;
        repeat (3) nxt();
        chk("reset_outputs", {busy, bus.req_ready, bus.rsp_valid, bus.rsp_id, bus.rsp_flags, bus.rsp_portout},
            {1'b0, 2'b00, 2'b00, 1'b0, 3'b000, 32'd0});
        chk("reset_alu_in", {alu_aluop, alu_porta, alu_portb}, {4'd0, 32'd0, 32'd0});
        rst = 1'b0;
        nxt();

        for (int k = 0; k < 12; k++) run_single(vecs[k]);

        // Contention: both hold valid; grants must alternate starting at 0
        bus.req_aluop[0] = ALU_SLT;  bus.req_porta[0] = 32'hFFFF_FFFF; bus.req_portb[0] = 32'd1;
        bus.req_aluop[1] = ALU_SLTU; bus.req_porta[1] = 32'hFFFF_FFFF; bus.req_portb[1] = 32'd1;
        bus.req_valid = 2'b11;
        bus.rsp_ready = 2'b11;
        ng = 0;
        nr = 0;
        for (int c = 0; c < 30 && nr < 4; c++) begin
            #1;
            if (bus.req_ready != 2'b00 && ng < 4) begin
                gseq[ng] = bus.req_ready;
                ng++;
            end
            if (bus.rsp_valid != 2'b00) begin
                chk("cont_rsp_id", bus.rsp_id, nr % 2);
                chk("cont_rsp_out", bus.rsp_portout, (nr % 2 == 0) ? 32'd1 : 32'd0);
                nr++;
            end
            nxt();
            if (ng >= 4) bus.req_valid = '0;
        end
        bus.rsp_ready = '0;
        chk("cont_counts", {ng[7:0], nr[7:0]}, {8'd4, 8'd4});
        chk("cont_order", {gseq[0], gseq[1], gseq[2], gseq[3]}, {2'b01, 2'b10, 2'b01, 2'b10});

        // Backpressure: owner 0 stalls 10 cycles while requester 1 waits
        bus.req_aluop[0] = ALU_ADD; bus.req_porta[0] = 32'd3; bus.req_portb[0] = 32'd4;
        bus.req_aluop[1] = ALU_ADD; bus.req_porta[1] = 32'd1; bus.req_portb[1] = 32'd1;
        bus.req_valid = 2'b11;
        #1;
        chk("bp_grant", bus.req_ready, 2'b01);
        nxt();
        bus.req_valid = 2'b10;
        nxt();
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            if (bus.rsp_valid !== 2'b01 || bus.rsp_portout !== 32'd7 || bus.req_ready !== 2'b00 || busy !== 1'b1)
                bad++;
            nxt();
        end
        chk("bp_hold", bad, 0);
        bus.rsp_ready = 2'b01;
        nxt();
        bus.rsp_ready = '0;
        #1;
        chk("bp_release", {busy, bus.req_ready}, {1'b0, 2'b10});
        nxt();
        bus.req_valid = '0;
        nxt();
        chk("bp_second", {bus.rsp_valid, bus.rsp_id, bus.rsp_portout}, {2'b10, 1'b1, 32'd2});
        bus.rsp_ready = 2'b10;
        nxt();
        bus.rsp_ready = '0;

        // Ready from a non-owner must not retire the response
        bus.req_aluop[0] = ALU_ADD; bus.req_porta[0] = 32'd2; bus.req_portb[0] = 32'd2;
        bus.req_valid = 2'b01;
        nxt();
        bus.req_valid = '0;
        nxt();
        bus.rsp_ready = 2'b10;
        nxt();
        chk("wrong_owner", {busy, bus.rsp_valid, bus.rsp_portout}, {1'b1, 2'b01, 32'd4});
        bus.rsp_ready = 2'b01;
        nxt();
        bus.rsp_ready = '0;
        chk("wrong_owner_done", busy, 1'b0);

        // Reset while requester 1 is in EXEC (last served was 0)
        bus.req_aluop[1] = ALU_ADD; bus.req_porta[1] = 32'd9; bus.req_portb[1] = 32'd9;
        bus.req_valid = 2'b10;
        #1;
        chk("rst_pre_grant", bus.req_ready, 2'b10);
        nxt();
        chk("rst_in_exec", busy, 1'b1);
        bus.req_aluop[0] = ALU_ADD; bus.req_porta[0] = 32'd1; bus.req_portb[0] = 32'd2;
        bus.req_valid = 2'b11;
        rst = 1'b1;
        nxt();
        chk("rst_outputs", {busy, bus.req_ready, bus.rsp_valid, bus.rsp_id, bus.rsp_flags, bus.rsp_portout,
                            alu_aluop, alu_porta, alu_portb},
            {1'b0, 2'b00, 2'b00, 1'b0, 3'b000, 32'd0, 4'd0, 32'd0, 32'd0});
        rst = 1'b0;
        #1;
        chk("rst_next_grant", bus.req_ready, 2'b01);
        nxt();
        bus.req_valid = '0;
        nxt();
        chk("rst_rsp", {bus.rsp_valid, bus.rsp_id, bus.rsp_portout}, {2'b01, 1'b0, 32'd3});
        bus.rsp_ready = 2'b01;
        nxt();
        bus.rsp_ready = '0;

        // Randomized traffic against the transaction model
        last = 0;
        pend = '0;
        for (int it = 0; it < 60; it++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!pend[i] && $urandom_range(0, 1) == 1) begin
                    pend[i] = 1'b1;
                    pop[i]  = aluop_t'($urandom_range(0, 15));
                    pa[i]   = $urandom;
                    pb[i]   = ($urandom_range(0, 3) == 0) ? pa[i] : $urandom;
                end
            end
            if (pend == '0) begin
                w       = $urandom_range(0, NREQ - 1);
                pend[w] = 1'b1;
                pop[w]  = ALU_SUB;
                pa[w]   = $urandom;
                pb[w]   = pa[w];
            end
            for (int i = 0; i < NREQ; i++) begin
                bus.req_aluop[i] = pop[i];
                bus.req_porta[i] = pa[i];
                bus.req_portb[i] = pb[i];
            end
            bus.req_valid = pend;
            w   = rr_winner(pend, last);
            exp = alu_calc(pop[w], pa[w], pb[w]);
            #1;
            chk("rnd_grant", bus.req_ready, onehot(w));
            nxt();
            pend[w]       = 1'b0;
            bus.req_valid = pend;
            nxt();
            chk("rnd_rsp_valid", bus.rsp_valid, onehot(w));
            chk("rnd_rsp_data", {bus.rsp_id, bus.rsp_flags, bus.rsp_portout}, {w[0], exp});
            repeat ($urandom_range(0, 3)) begin
                bus.rsp_ready = NREQ'($urandom) & ~onehot(w);
                nxt();
            end
            bus.rsp_ready = onehot(w) | NREQ'($urandom);
            nxt();
            bus.rsp_ready = '0;
            last = w;
            chk("rnd_idle", busy, 1'b0);
        end
        bus.req_valid = '0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
